// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : load/store alignment unit in front of data_mem. Word-crossing
//             accesses are split over two cycles when LSU_MISALIGN_EN is
//             defined; otherwise they are suppressed and flagged.
// Revision  : 1.0
// ============================================================================

module lsu_align #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  misalign_err,
  output logic                  dm_wr_en,
  output logic [2:0]            dm_funct3,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic [DATA_WIDTH-1:0] dm_wr_data,
  input  logic [DATA_WIDTH-1:0] dm_rd_data
);

  logic [1:0] off;
  logic       supported;
  logic       spanning;
  logic       pass_we;

  assign off = addr[1:0];

  always_comb begin
    case (funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: supported = 1'b1;
      default:                                supported = 1'b0;
    endcase
  end

  // A byte never spans; a half spans only from offset 3.
  assign spanning = mem_req & supported &
                    (((funct3[1:0] == 2'b10) & (off != 2'd0)) |
                     ((funct3[1:0] == 2'b01) & (off == 2'd3)));
  assign pass_we  = mem_req & mem_we & supported & ~reset;

`ifdef LSU_MISALIGN_EN
  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sh_addr_q, sh_addr_d;
  logic [2:0]            sh_funct3_q, sh_funct3_d;
  logic                  sh_we_q, sh_we_d;
  logic [DATA_WIDTH-1:0] sh_wdata_q, sh_wdata_d;
  logic [DATA_WIDTH-1:0] lo_buf_q, lo_buf_d;
  logic [ADDR_WIDTH-3:0] sh_word_nxt;
  logic [1:0]            sh_off, lo_cnt, hi_cnt;
  logic [DATA_WIDTH-1:0] mask_lo, mask_hi, merged;
  logic                  first_half;

  assign first_half  = (state_q == S_IDLE) & spanning;
  assign sh_word_nxt = sh_addr_q[ADDR_WIDTH-1:2] + {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
  assign sh_off      = sh_addr_q[1:0];
  assign lo_cnt      = 2'd0 - sh_off;  // bytes taken from the first word (4 - o)
  assign hi_cnt      = (sh_funct3_q[1:0] == 2'b10) ? sh_off : 2'd1;
  assign mask_lo     = {DATA_WIDTH{1'b1}} << {off, 3'b000};
  assign mask_hi     = ~({DATA_WIDTH{1'b1}} << {hi_cnt, 3'b000});
  assign merged      = lo_buf_q | (dm_rd_data << {lo_cnt, 3'b000});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sh_addr_q   <= '0;
      sh_funct3_q <= '0;
      sh_we_q     <= 1'b0;
      sh_wdata_q  <= '0;
      lo_buf_q    <= '0;
    end else begin
      state_q     <= state_d;
      sh_addr_q   <= sh_addr_d;
      sh_funct3_q <= sh_funct3_d;
      sh_we_q     <= sh_we_d;
      sh_wdata_q  <= sh_wdata_d;
      lo_buf_q    <= lo_buf_d;
    end
  end

  // Address/control path; kept apart from the data path because dm_rd_data
  // is combinational from dm_addr.
  always_comb begin
    state_d     = state_q;
    sh_addr_d   = sh_addr_q;
    sh_funct3_d = sh_funct3_q;
    sh_we_d     = sh_we_q;
    sh_wdata_d  = sh_wdata_q;
    dm_addr     = addr;
    dm_funct3   = funct3;
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (spanning) begin
          state_d     = S_SECOND;
          sh_addr_d   = addr;
          sh_funct3_d = funct3;
          sh_we_d     = mem_we;
          sh_wdata_d  = wdata;
          stall       = ~reset;
          dm_addr     = {addr[ADDR_WIDTH-1:2], 2'b00};
          dm_funct3   = 3'b010;
        end
      end
      S_SECOND: begin
        state_d   = S_IDLE;
        dm_addr   = {sh_word_nxt, 2'b00};
        dm_funct3 = 3'b010;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lo_buf_d   = lo_buf_q;
    dm_wr_data = wdata;
    dm_wr_en   = pass_we;
    rdata      = dm_rd_data;
    if (state_q == S_SECOND) begin
      dm_wr_en   = sh_we_q & ~reset;
      dm_wr_data = (dm_rd_data & ~mask_hi) |
                   ((sh_wdata_q >> {lo_cnt, 3'b000}) & mask_hi);
      if (sh_funct3_q[1:0] == 2'b01)
        rdata = {{16{merged[15] & ~sh_funct3_q[2]}}, merged[15:0]};
      else
        rdata = merged;
    end else if (first_half) begin
      dm_wr_en   = mem_we & ~reset;
      dm_wr_data = (dm_rd_data & ~mask_lo) | ((wdata << {off, 3'b000}) & mask_lo);
      if (!mem_we)
        lo_buf_d = dm_rd_data >> {off, 3'b000};
    end
  end

  assign misalign_err = 1'b0;

`else
  logic misalign_q, misalign_d;

  assign misalign_d = misalign_q | spanning;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  always_comb begin
    dm_addr    = addr;
    dm_funct3  = funct3;
    dm_wr_data = wdata;
    stall      = 1'b0;
    dm_wr_en   = pass_we & ~spanning;
    rdata      = spanning ? '0 : dm_rd_data;
  end

  assign misalign_err = misalign_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ============================================================================
// tb_lsu_align : scoreboard bench for lsu_align with a byte-addressed data_mem
//                model; covers both LSU_MISALIGN_EN builds.
// Revision     : 1.0
// ============================================================================

module tb_lsu_align;

`ifdef LSU_MISALIGN_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misalign_err, dm_wr_en;
  logic [2:0]  dm_funct3;
  logic [31:0] dm_addr, dm_wr_data, dm_rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  logic [7:0] mem [64];
  logic [5:0] ra;

  lsu_align #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .misalign_err(misalign_err), .dm_wr_en(dm_wr_en),
    .dm_funct3(dm_funct3), .dm_addr(dm_addr), .dm_wr_data(dm_wr_data),
    .dm_rd_data(dm_rd_data)
  );

  always #5 clk = ~clk;

  // data_mem model: combinational extended read, byte-enabled write
  assign ra = dm_addr[5:0];
  always_comb begin
    case (dm_funct3)
      3'b000:  dm_rd_data = {{24{mem[ra][7]}}, mem[ra]};
      3'b100:  dm_rd_data = {24'h0, mem[ra]};
      3'b001:  dm_rd_data = {{16{mem[ra+6'd1][7]}}, mem[ra+6'd1], mem[ra]};
      3'b101:  dm_rd_data = {16'h0, mem[ra+6'd1], mem[ra]};
      default: dm_rd_data = {mem[ra+6'd3], mem[ra+6'd2], mem[ra+6'd1], mem[ra]};
    endcase
  end

  always @(posedge clk) begin
    if (dm_wr_en) begin
      mem[ra] <= dm_wr_data[7:0];
      if (dm_funct3[1:0] != 2'b00) mem[ra+6'd1] <= dm_wr_data[15:8];
      if (dm_funct3[1:0] == 2'b10) begin
        mem[ra+6'd2] <= dm_wr_data[23:16];
        mem[ra+6'd3] <= dm_wr_data[31:24];
      end
    end
  end

  function automatic logic [31:0] mw(input logic [5:0] a);
    return {mem[a+6'd3], mem[a+6'd2], mem[a+6'd1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Load result is valid whenever a load is presented and the core is not stalled.
  always @(negedge clk) begin
    if (!reset && mem_req && !mem_we && !stall) begin
      if (exp_q.size() == 0) check("sb_unexpected_load", rdata, 32'hx);
      else check("rdata", rdata, exp_q.pop_front());
    end
  end

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic span);
    logic split;
    split = span & SPLIT;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    if (!we) exp_q.push_back(exp_rd);
    @(negedge clk);
    check("stall_first", {31'h0, stall}, {31'h0, split});
    if (split) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_second", {31'h0, stall}, 32'h0);
    end
    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a spanning store presented: nothing may stall or write.
    reset = 1'b1; mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b010;
    addr = 32'h5; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_wr_en", {31'h0, dm_wr_en}, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0; mem_req = 1'b0; mem_we = 1'b0;

    // Aligned path
    access(1, 3'b010, 32'h4, 32'hDDCC_BBAA, 0, 0);
    access(1, 3'b010, 32'h8, 32'h4433_2211, 0, 0);
    check("mem4", mw(6'h4), 32'hDDCC_BBAA);
    access(0, 3'b100, 32'h6, 0, 32'h0000_00CC, 0);
    access(0, 3'b000, 32'h7, 0, 32'hFFFF_FFDD, 0);
    access(0, 3'b001, 32'h5, 0, 32'hFFFF_CCBB, 0);
    access(0, 3'b101, 32'h6, 0, 32'h0000_DDCC, 0);
    access(0, 3'b010, 32'h4, 0, 32'hDDCC_BBAA, 0);
    check("misalign_aligned", {31'h0, misalign_err}, 32'h0);

    // Spanning loads
    access(0, 3'b010, 32'h5, 0, SPLIT ? 32'h11DD_CCBB : 32'h0, 1);
    check("misalign_after_span", {31'h0, misalign_err}, {31'h0, !SPLIT});
    access(1, 3'b000, 32'h8, 32'h0000_00F1, 0, 0);
    access(0, 3'b001, 32'h7, 0, SPLIT ? 32'hFFFF_F1DD : 32'h0, 1);
    access(0, 3'b101, 32'h7, 0, SPLIT ? 32'h0000_F1DD : 32'h0, 1);

    // Sub-word stores and an unsupported size code
    access(1, 3'b001, 32'hA, 32'h0000_1234, 0, 0);
    access(1, 3'b000, 32'h9, 32'h0000_0099, 0, 0);
    access(0, 3'b010, 32'h8, 0, 32'h1234_99F1, 0);
    access(1, 3'b011, 32'h9, 32'hFFFF_FFFF, 0, 0);
    check("mem8_unsupported", mw(6'h8), 32'h1234_99F1);

    // Spanning stores
    access(1, 3'b010, 32'hC,  32'h0, 0, 0);
    access(1, 3'b010, 32'h10, 32'h0, 0, 0);
    access(1, 3'b010, 32'hE,  32'hA1B2_C3D4, 0, 1);
    check("memC_sw", mw(6'hC),  SPLIT ? 32'hC3D4_0000 : 32'h0);
    check("mem10_sw", mw(6'h10), SPLIT ? 32'h0000_A1B2 : 32'h0);
    access(1, 3'b001, 32'hF, 32'h0000_5566, 0, 1);
    check("memC_sh", mw(6'hC),  SPLIT ? 32'h66D4_0000 : 32'h0);
    check("mem10_sh", mw(6'h10), SPLIT ? 32'h0000_A155 : 32'h0);

    // Second word address wraps past the top of the address space
    access(1, 3'b010, 32'hFFFF_FFFC, 32'h1A2B_3C4D, 0, 0);
    access(1, 3'b010, 32'h0,         32'h0A0B_0C0D, 0, 0);
    access(0, 3'b010, 32'hFFFF_FFFE, 0, SPLIT ? 32'h0C0D_1A2B : 32'h0, 1);

`ifdef LSU_MISALIGN_EN
    // Reset during SECOND of a split store: only the first word lands.
    access(1, 3'b010, 32'hC,  32'h0, 0, 0);
    access(1, 3'b010, 32'h10, 32'h5566_7788, 0, 0);
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b010; addr = 32'hE; wdata = 32'hA1B2_C3D4;
    @(negedge clk);
    check("rst_split_stall1", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_split_stall", {31'h0, stall}, 32'h0);
    check("rst_split_wr_en", {31'h0, dm_wr_en}, 32'h0);
    @(posedge clk); #1;
    mem_req = 1'b0; mem_we = 1'b0;
    reset = 1'b0;
    check("rst_split_memC", mw(6'hC), 32'hC3D4_0000);
    check("rst_split_mem10", mw(6'h10), 32'h5566_7788);
    access(0, 3'b010, 32'h10, 0, 32'h5566_7788, 0);
    check("misalign_tied", {31'h0, misalign_err}, 32'h0);
`else
    // Flag is sticky until reset.
    access(0, 3'b010, 32'h4, 0, 32'hDDCC_BBAA, 0);
    check("misalign_sticky", {31'h0, misalign_err}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("misalign_cleared", {31'h0, misalign_err}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    access(0, 3'b001, 32'h6, 0, 32'hFFFF_DDCC, 0);
    check("misalign_stays_clear", {31'h0, misalign_err}, 32'h0);
`endif

    repeat (2) @(posedge clk);
    check("sb_left", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit sitting directly upstream of the data memory, between the core datapath and `data_mem`. It passes naturally aligned byte, half and word accesses straight through in one cycle. Word and half accesses that cross a 32-bit word boundary are split into two aligned word accesses over two cycles, with a stall to the core. Split stores use read-modify-write; split loads merge two words, then sign- or zero-extend the result.

## Interface
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data width; only 32 is supported.
- `clk`  in  1  single clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_req`  in  1  core presents a load or store this cycle.
- `mem_we`  in  1  1 = store, 0 = load; qualified by `mem_req`.
- `funct3`  in  3  RV32I size code: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- `addr`  in  ADDR_WIDTH  byte address.
- `wdata`  in  DATA_WIDTH  store data, right-justified.
- `rdata`  out  DATA_WIDTH  extended load result to the core.
- `stall`  out  1  core holds PC and pipeline registers this cycle.
- `misalign_err`  out  1  registered sticky flag; only driven when `LSU_MISALIGN_EN` is undefined.
- `dm_wr_en`  out  1  data memory write enable.
- `dm_funct3`  out  3  data memory size code.
- `dm_addr`  out  ADDR_WIDTH  data memory byte address.
- `dm_wr_data`  out  DATA_WIDTH  data memory write data.
- `dm_rd_data`  in  DATA_WIDTH  data memory read data; combinational from `dm_addr`/`dm_funct3`.

## Operation
- Offset `o = addr[1:0]`; size `n` = 1, 2 or 4 bytes from `funct3[1:0]`.
- Spanning access: `o + n > 4`. This is a word with `o != 0`, or a half with `o == 3`. A byte access never spans.
- FSM states:
  - IDLE (reset state).
  - SECOND.
- Transitions:
  - IDLE → SECOND on a spanning `mem_req`.
  - SECOND → IDLE unconditionally.
- IDLE, non-spanning access (pass-through):
  - `dm_addr = addr`, `dm_funct3 = funct3`, `dm_wr_data = wdata`, `dm_wr_en = mem_req & mem_we`.
  - `rdata = dm_rd_data`.
  - `stall = 0`.
- IDLE, spanning access (first half):
  - `stall = 1`.
  - `dm_addr = {addr[31:2], 2'b00}`, `dm_funct3 = 010`.
  - Latch `addr`, `funct3`, `mem_we` and `wdata` into shadow registers.
  - Load: latch bytes `o..3` of `dm_rd_data` into `lo_buf`. `dm_wr_en = 0`.
  - Store: `dm_wr_data = (dm_rd_data & ~mask_lo) | ((wdata << 8*o) & mask_lo)`, where `mask_lo` covers bytes `o..3`. `dm_wr_en = 1`.
- SECOND (uses shadow registers only; `stall = 0`):
  - `dm_addr = {shadow_addr[31:2] + 1, 2'b00}`; wraps modulo 2^ADDR_WIDTH. `dm_funct3 = 010`.
  - Load: merge `lo_buf` (low bytes) with bytes `0..o+n-5` of `dm_rd_data` (high bytes). Sign-extend for lh/lw, zero-extend for lhu. Drive the result on `rdata`.
  - Store: read-modify-write bytes `0..o+n-5` with the remaining upper bytes of `shadow_wdata`. `dm_wr_en = 1`.
- Core inputs during SECOND are ignored; the core holds them stable anyway.
- `mem_req = 0` in IDLE: `dm_wr_en = 0`, `stall = 0`, `rdata = dm_rd_data`.
- Unsupported `funct3` (011, 110, 111): pass-through with `dm_wr_en = 0`, no split.

## Timing
- Reset values:
  - FSM = IDLE.
  - `lo_buf`, all shadow registers and `misalign_err` = 0.
  - Combinational outputs follow IDLE rules with `mem_req` as driven; `stall = 0` and `dm_wr_en = 0` whenever `reset` is high.
- Latency:
  - Aligned access: 0 extra cycles; load data valid in the same cycle, store committed at the next edge.
  - Spanning access: exactly 1 extra cycle. Load data is valid in the SECOND cycle; the store's second word is committed at the end of SECOND.
- Back-to-back: a new access is accepted in the cycle after SECOND.
- Reset asserted during SECOND: the FSM returns to IDLE and the second write is not performed. The first-half write stays committed (documented partial store).

## Configuration
- `LSU_MISALIGN_EN` defined: split behaviour as above; `misalign_err` tied 0.
- `LSU_MISALIGN_EN` undefined:
  - No SECOND state; `stall` tied 0.
  - A spanning access forces `dm_wr_en = 0` and `rdata = 0`.
  - `misalign_err` sets to 1 at the next edge and stays set until reset.

## Test plan
- Aligned path: sw 0xDDCCBBAA @0x4, then lbu @0x6 → `rdata` = 0x000000CC and lb @0x7 → `rdata` = 0xFFFFFFDD, both with `stall` = 0.
- Spanning lw: word 0x4 = 0xDDCCBBAA, word 0x8 = 0x44332211; lw @0x5 → `stall` = 1 for one cycle, then `rdata` = 0x11DDCCBB.
- Spanning lh/lhu: word 0x8 = 0x443322F1; lh @0x7 → 0xFFFFF1DD; lhu @0x7 → 0x0000F1DD.
- Spanning sw: both words 0; sw 0xA1B2C3D4 @0xE → word 0xC = 0xC3D40000 and word 0x10 = 0x0000A1B2.
- Reset mid-split: assert `reset` during SECOND of sw @0xE → word 0x10 unchanged, FSM = IDLE, `stall` = 0.
- Macro undefined: lw @0x5 → `misalign_err` = 1 next cycle, `rdata` = 0, no write, `stall` = 0.
